mem_stage: RTL

- Pipeline MEM stage. Sits between the EX/MEM register and MEM_WB.
- Executes RV32I loads and stores against data memory using a req/ack handshake.
- Decodes memory-mapped IO (LED, 7-seg, switches), aligns/extends load data, and drives the MEM_WB inputs.
- Stalls upstream while a RAM access is outstanding.

---
 rtl/riscv_defs.sv | 22 ++
 rtl/mem_align.sv | 54 +++++
 rtl/mem_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/riscv_defs.sv
// Shared RV32I definitions for the MEM stage: funct3 sizes,
// memory-mapped IO addresses and the MEM access FSM states.
package riscv_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;
    localparam logic [31:0] LED_ADDR = 32'hFFFF_FC60;
    localparam logic [31:0] SW_ADDR  = 32'hFFFF_FC70;
    localparam logic [31:0] SEG_ADDR = 32'hFFFF_FC80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memState_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store byte enables and replication,
// load byte/half extraction with sign/zero extension, alignment check.
module mem_align
    import riscv_defs::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byteOff,
    input  logic [31:0] storeData,
    input  logic [31:0] loadWord,
    output logic [3:0]  byteEn,
    output logic [31:0] storeLanes,
    output logic [31:0] loadData,
    output logic        misaligned
);

    logic [31:0] shifted;
    logic        isByte;
    logic        isHalf;
    logic        unsignedLd;

    assign shifted    = loadWord >> {byteOff, 3'b000};
    assign isByte     = funct3[1:0] == F3_B[1:0];
    assign isHalf     = funct3[1:0] == F3_H[1:0];
    assign unsignedLd = funct3[2];

    always_comb begin
        byteEn     = 4'b0000;
        storeLanes = '0;
        loadData   = '0;
        misaligned = 1'b0;
        unique case (1'b1)
            isByte: begin
                byteEn     = 4'b0001 << byteOff;
                storeLanes = {4{storeData[7:0]}};
                loadData   = unsignedLd ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            isHalf: begin
                misaligned = byteOff[0];
                byteEn     = byteOff[1] ? 4'b1100 : 4'b0011;
                storeLanes = {2{storeData[15:0]}};
                loadData   = unsignedLd ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                misaligned = |byteOff;
                byteEn     = 4'b1111;
                storeLanes = storeData;
                loadData   = loadWord;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: RAM access over req/ack with timeout, IO decode,
// load alignment, and bubble insertion toward MEM_WB while stalled.
module mem_stage
    import riscv_defs::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic        in_MemtoReg,
    input  logic        in_RegWrite,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd_addr,
    input  logic [31:0] in_ALUResult,
    input  logic [31:0] in_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    input  logic [15:0] io_sw,
    output logic        stall,
    output logic        MEM_MemtoReg,
    output logic        MEM_RegWrite,
    output logic        MEM_ioWrite,
    output logic        MEM_SegCtrl,
    output logic        MEM_LEDCtrl,
    output logic [4:0]  MEM_rd_addr,
    output logic [31:0] MEM_ALUResult,
    output logic [31:0] MEM_MemData,
    output logic        misalign_err,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    memState_t   state;
    logic [CW-1:0] waitCnt;
    logic [31:0] rdataQ;
    logic        busErrQ;

    logic [3:0]  byteEn;
    logic [31:0] storeLanes;
    logic [31:0] loadData;
    logic [31:0] loadWord;
    logic [31:0] ioWord;
    logic        misaligned;
    logic        isMem, isIo, idle, memOp;
    logic        ramOp, ioOp, misalignHit, present;
    logic        ledWr, segWr;

    mem_align uAlign (
        .funct3     (in_funct3),
        .byteOff    (in_ALUResult[1:0]),
        .storeData  (in_store_data),
        .loadWord   (loadWord),
        .byteEn     (byteEn),
        .storeLanes (storeLanes),
        .loadData   (loadData),
        .misaligned (misaligned)
    );

    assign isMem       = in_MemRead | in_MemWrite;
    assign isIo        = in_ALUResult >= IO_BASE;
    assign idle        = state == IDLE;
    assign memOp       = in_valid & isMem & ~misaligned;
    assign ramOp       = idle & memOp & ~isIo;
    assign ioOp        = idle & memOp & isIo;
    assign misalignHit = idle & in_valid & isMem & misaligned;

    assign ioWord   = (in_ALUResult == SW_ADDR) ? {16'b0, io_sw} : 32'b0;
    assign loadWord = (state == DONE) ? rdataQ : ioWord;

    // The instruction is only handed to MEM_WB on a non-stalled cycle.
    assign stall   = ramOp | (state == WAIT);
    assign present = in_valid & ~stall;

    assign ledWr = ioOp & in_MemWrite & (in_ALUResult == LED_ADDR);
    assign segWr = ioOp & in_MemWrite & (in_ALUResult == SEG_ADDR);

    assign MEM_RegWrite  = present & in_RegWrite & ~misalignHit
                         & ~((state == DONE) & busErrQ);
    assign MEM_MemtoReg  = present & in_MemtoReg;
    assign MEM_ioWrite   = ledWr | segWr;
    assign MEM_LEDCtrl   = ledWr;
    assign MEM_SegCtrl   = segWr;
    assign MEM_rd_addr   = in_rd_addr;
    assign MEM_ALUResult = in_ALUResult;
    assign MEM_MemData   = (present & in_MemRead & ~misalignHit)
                         ? loadData : 32'b0;
    assign misalign_err  = misalignHit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            waitCnt    <= '0;
            rdataQ     <= '0;
            busErrQ    <= 1'b0;
            bus_err    <= 1'b0;
            err_addr   <= '0;
        end else begin
            bus_err <= 1'b0;
            if (misalignHit) begin
                err_addr <= in_ALUResult;
            end
            unique case (state)
                IDLE: begin
                    if (ramOp) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= in_MemWrite;
                        dmem_addr  <= in_ALUResult[31:2];
                        dmem_be    <= byteEn;
                        dmem_wdata <= storeLanes;
                        waitCnt    <= '0;
                        busErrQ    <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        rdataQ   <= dmem_rdata;
                        dmem_req <= 1'b0;
                        waitCnt  <= '0;
                        state    <= DONE;
                    end else if (waitCnt == LAST) begin
                        bus_err  <= 1'b1;
                        err_addr <= in_ALUResult;
                        busErrQ  <= 1'b1;
                        dmem_req <= 1'b0;
                        waitCnt  <= '0;
                        state    <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                DONE: begin
                    busErrQ <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
